vpu_fp_result_collector: RTL and testbench
==========================================

// Module: vpu_fp_result_collector
// PURPOSE
//  Receive side of the FP-unit start/done handshake: sits between a fixed-latency FP pipeline
//  (e.g. the bf16 EXP unit) and VPU_DST_PORT. The FP pipeline has no back-pressure, so this
//  block grants issue slots by credit. Credits = free FIFO entries minus ops in flight.
//  It buffers done results and presents them downstream on a valid/ready interface. It also
//  supports a flush that drains in-flight ops without delivering them.
// PARAMETERS
//  DATA_WIDTH  16  result width (VPU_PKG::OPERAND_WIDTH, bf16)
//  DEPTH        8  result FIFO entries; also max in-flight ops; power of 2, >=2
//  CNT_W  $clog2(DEPTH)+1  width of the occupancy/in-flight counters
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           synchronous active-low reset
//  issue_req_i  in   1           SRC side requests to start one op this cycle
//  issue_gnt_o  out  1           credit available; op may start this cycle
//  start_o      out  1           to FP unit start_i; = issue_req_i & issue_gnt_o
//  done_i       in   1           from FP unit done_o
//  result_i     in   DATA_WIDTH  from FP unit result_o; valid when done_i=1
//  valid_o      out  1           result available to DST_PORT
//  data_o       out  DATA_WIDTH  result to DST_PORT
//  ready_i      in   1           DST_PORT accepts; pop when valid_o & ready_i
//  flush_i      in   1           discard FIFO contents and all in-flight results
//  busy_o       out  1           inflight!=0 or FIFO non-empty or state==DRAIN
//  inflight_o   out  CNT_W       ops started but not yet done
//  err_o        out  1           sticky; spurious done_i, or done_i with FIFO full
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous active-low on rst_n; it applies on the first edge with
//    rst_n=0 and overrides every other input.
//  - Reset values: FIFO empty, inflight=0, state=RUN, err_o=0, valid_o=0, data_o=0,
//    issue_gnt_o=1, start_o=0, busy_o=0.
//  - State machine:
//    * RUN: normal operation. Goes to DRAIN on flush_i=1 when inflight (after this cycle's
//      update) is !=0; otherwise stays in RUN.
//    * DRAIN: issue_gnt_o=0. Every done_i decrements inflight; its data is dropped. Goes to RUN
//      on the edge where inflight reaches 0. flush_i is ignored while in DRAIN.
//  - Flush: on the flush_i edge, the FIFO is cleared (rd/wr pointers reset, valid_o=0 next
//    cycle). A same-cycle pop is ignored. A same-cycle done_i is counted but not stored.
//  - Credit: issue_gnt_o = (state==RUN) & (count + inflight < DEPTH), using registered values.
//    A same-cycle pop does not add credit until the next cycle.
//  - Counters, per edge:
//    * inflight += start_o - done_i.
//    * count += push - pop, where push = done_i & state==RUN & ~flush_i.
//    * start and done in the same cycle leave inflight unchanged; push and pop in the same cycle
//      leave count unchanged.
//  - FIFO: first-word-fall-through; data_o = mem[rd_ptr]. Pointers are log2(DEPTH) bits and wrap
//    modulo DEPTH. Latency done_i -> valid_o = 1 cycle.
//  - Back-pressure: while ready_i=0, valid_o/data_o hold stable. Results leave in done order.
//  - Error cases:
//    * done_i with inflight==0: err_o<=1, data dropped, inflight stays 0 (no underflow).
//    * done_i with count==DEPTH (unreachable by the credit rule): err_o<=1, data dropped.
//    * err_o clears only on reset.
//  - issue_req_i with issue_gnt_o=0: start_o=0; the request is not queued here.
// CONFIGURATION
//  VPU_COLLECT_BYPASS_EN defined:
//    * When the FIFO is empty, state==RUN, ~flush_i, done_i=1 and ready_i=1: valid_o=1 and
//      data_o=result_i in the same cycle (combinational path).
//    * The result is consumed without a push; count is unchanged.
//    * The done -> valid_o latency becomes 0 in that case.
//  Not defined: valid_o and data_o are purely registered/FIFO-driven; latency is always 1.
// TESTING (DEPTH=4)
//  - Reset, all inputs 0 -> valid_o=0, issue_gnt_o=1, inflight_o=0, err_o=0, busy_o=0.
//  - 1 start; 3 cycles later done_i with result_i=16'h3F80, ready_i=1 -> valid_o=1 with
//    data_o=3F80 for exactly 1 cycle, 1 cycle after done_i (0 cycles with BYPASS_EN);
//    inflight_o 1->0.
//  - ready_i=0, issue_req_i=1 held -> exactly 4 start_o pulses, then issue_gnt_o=0. Returns
//    0x3F80,0x4000,0x402E,0x4080 -> count=4. Raise ready_i -> data_o in that order on
//    4 consecutive cycles, then issue_gnt_o=1.
//  - In the same cycle, start_o=1, done_i=1 and a pop -> inflight and count unchanged; data
//    order preserved.
//  - 2 in flight plus 1 in FIFO, flush_i pulse -> valid_o=0 next cycle; state=DRAIN,
//    issue_gnt_o=0; 2 done_i dropped -> RUN, issue_gnt_o=1, err_o=0.
//  - done_i with inflight=0 -> err_o=1 and stays 1; no valid_o. rst_n=0 mid-burst -> every
//    output at its reset value after 1 edge.

Source files
------------

// File: rtl/vpu_fp_result_collector.sv
// vpu_fp_result_collector
//   Receive side of an FP-unit start/done handshake. It grants issue slots to the
//   source by credit, because the fixed-latency FP pipeline cannot be stalled. It
//   buffers done results in a first-word-fall-through FIFO toward the destination
//   port, and it drains in-flight ops without delivering them after a flush.
//
//   Optional feature: define VPU_COLLECT_BYPASS_EN to forward a done result
//   combinationally when the FIFO is empty and the destination is ready.
//
//   Handshake (output side): a result transfers on a cycle where valid_o and
//   ready_i are both 1. While ready_i=0, valid_o and data_o hold stable, and
//   valid_o is never withdrawn except by flush_i or reset.
//
//   Debug: state_o exposes the FSM state (0 = RUN, 1 = DRAIN).
module vpu_fp_result_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_req_i,
  output logic                  issue_gnt_o,
  output logic                  start_o,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      inflight_o,
  output logic                  err_o,
  output logic                  state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [0:0]            state;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      inflight_next;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  err;

  logic                  run;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W:0]        credit_sum;
  logic                  done_known;
  logic                  flush_run;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  err_set;

  // Credit, handshake and FIFO control decisions for this cycle
  always_comb begin
    run        = (state == ST_RUN);
    fifo_empty = (count == '0);
    fifo_full  = (count == DEPTH_C);
    // Occupied slots plus ops that will still land; both are registered values,
    // so a pop in this cycle only frees credit from the next cycle on.
    credit_sum  = {1'b0, count} + {1'b0, inflight};
    issue_gnt_o = run & (credit_sum < {1'b0, DEPTH_C});
    start_o     = issue_req_i & issue_gnt_o;
    // A done with nothing in flight is spurious: flagged and never counted.
    done_known  = done_i & (inflight != '0);
    flush_run   = flush_i & run;
`ifdef VPU_COLLECT_BYPASS_EN
    bypass = done_known & run & ~flush_i & fifo_empty & ready_i;
`else
    bypass = 1'b0;
`endif
    push    = done_known & run & ~flush_i & ~fifo_full & ~bypass;
    pop     = ~fifo_empty & ready_i & ~flush_run;
    err_set = done_i & ((inflight == '0) | fifo_full);
    inflight_next = inflight + CNT_W'(start_o) - CNT_W'(done_known);
  end

  // Output view: FIFO head first, otherwise the bypassed result, otherwise zero
  always_comb begin
    valid_o = ~fifo_empty | bypass;
    data_o  = '0;
    if (!fifo_empty) begin
      data_o = mem[rd_ptr];
    end else if (bypass) begin
      data_o = result_i;
    end
    busy_o     = (inflight != '0) | ~fifo_empty | (state == ST_DRAIN);
    inflight_o = inflight;
    err_o      = err;
    state_o    = state;
  end

  // Counters, pointers, sticky error and RUN/DRAIN state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      count    <= '0;
      inflight <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      err      <= err | err_set;
      inflight <= inflight_next;
      if (flush_run) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      case (state)
        ST_RUN:   if (flush_i && (inflight_next != '0)) state <= ST_DRAIN;
        ST_DRAIN: if (inflight_next == '0) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // Result storage; contents are only observed behind a valid count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result_i;
  end

endmodule

// File: tb/tb_vpu_fp_result_collector.sv
// Testbench for vpu_fp_result_collector (DEPTH=4): directed vector table for the
// documented scenarios, then randomized traffic against a queue-based model,
// with a reset asserted in the middle of random traffic.
module tb_vpu_fp_result_collector;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef VPU_COLLECT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           issue_req_i = 1'b0;
  logic           issue_gnt_o;
  logic           start_o;
  logic           done_i = 1'b0;
  logic [DW-1:0]  result_i = '0;
  logic           valid_o;
  logic [DW-1:0]  data_o;
  logic           ready_i = 1'b0;
  logic           flush_i = 1'b0;
  logic           busy_o;
  logic [CNT_W-1:0] inflight_o;
  logic           err_o;
  logic           state_o;

  int total = 0;
  int bad   = 0;

  vpu_fp_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_req_i(issue_req_i), .issue_gnt_o(issue_gnt_o), .start_o(start_o),
    .done_i(done_i), .result_i(result_i),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .flush_i(flush_i), .busy_o(busy_o), .inflight_o(inflight_o),
    .err_o(err_o), .state_o(state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];   // results accepted but not yet delivered
  int  m_infl;
  bit  m_drain;
  bit  m_err;

  task automatic model_reset();
    exp_q.delete();
    m_infl  = 0;
    m_drain = 0;
    m_err   = 0;
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit req, input bit done, input logic [DW-1:0] res,
                      input bit rdy, input bit fl);
    int sz;
    bit e_gnt, e_start, e_byp, e_valid, took;
    logic [DW-1:0] e_data;
    @(negedge clk);
    issue_req_i = req; done_i = done; result_i = res; ready_i = rdy; flush_i = fl;
    #1;
    sz      = exp_q.size();
    e_gnt   = !m_drain && (sz + m_infl < DEPTH);
    e_start = req && e_gnt;
    e_byp   = BYP && sz == 0 && !m_drain && !fl && done && m_infl > 0 && rdy;
    e_valid = (sz > 0) || e_byp;
    e_data  = (sz > 0) ? exp_q[0] : res;
    check("rnd gnt", 32'(issue_gnt_o), 32'(e_gnt));
    check("rnd start", 32'(start_o), 32'(e_start));
    check("rnd valid", 32'(valid_o), 32'(e_valid));
    if (e_valid) check("rnd data", 32'(data_o), 32'(e_data));
    check("rnd inflight", 32'(inflight_o), 32'(m_infl));
    check("rnd err", 32'(err_o), 32'(m_err));
    check("rnd busy", 32'(busy_o), 32'(m_infl != 0 || sz > 0 || m_drain));
    check("rnd state", 32'(state_o), 32'(m_drain));
    // advance the model across the edge
    if (done && (m_infl == 0 || (!m_drain && sz == DEPTH))) m_err = 1;
    took = done && m_infl > 0;
    if (!m_drain) begin
      if (fl) exp_q.delete();
      else begin
        if (rdy && sz > 0) void'(exp_q.pop_front());
        if (took && sz < DEPTH && !e_byp) exp_q.push_back(res);
      end
    end
    m_infl = m_infl + int'(e_start) - int'(took);
    if (!m_drain) m_drain = fl && (m_infl != 0);
    else          m_drain = (m_infl != 0);
  endtask

  // Reset asserted for one edge with whatever inputs are currently driven
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    issue_req_i = 0; done_i = 0; result_i = '0; ready_i = 0; flush_i = 0;
    #1;
    check({tag, " valid"}, 32'(valid_o), 32'd0);
    check({tag, " data"}, 32'(data_o), 32'd0);
    check({tag, " gnt"}, 32'(issue_gnt_o), 32'd1);
    check({tag, " start"}, 32'(start_o), 32'd0);
    check({tag, " inflight"}, 32'(inflight_o), 32'd0);
    check({tag, " err"}, 32'(err_o), 32'd0);
    check({tag, " busy"}, 32'(busy_o), 32'd0);
    check({tag, " state"}, 32'(state_o), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit req; bit done; logic [DW-1:0] res; bit rdy; bit fl;
    bit gnt; bit start; bit valid; logic [DW-1:0] data; int infl; bit err; bit busy; bit drain;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit req, bit done, logic [DW-1:0] res, bit rdy, bit fl,
                              bit gnt, bit start, bit valid, logic [DW-1:0] data,
                              int infl, bit err, bit busy, bit drain);
    vec_t v;
    v.req = req; v.done = done; v.res = res; v.rdy = rdy; v.fl = fl;
    v.gnt = gnt; v.start = start; v.valid = valid; v.data = data;
    v.infl = infl; v.err = err; v.busy = busy; v.drain = drain;
    return v;
  endfunction

  task automatic apply_row(input vec_t v, input int idx);
    string p;
    p = $sformatf("row%0d", idx);
    @(negedge clk);
    issue_req_i = v.req; done_i = v.done; result_i = v.res; ready_i = v.rdy; flush_i = v.fl;
    #1;
    check({p, " gnt"}, 32'(issue_gnt_o), 32'(v.gnt));
    check({p, " start"}, 32'(start_o), 32'(v.start));
    check({p, " valid"}, 32'(valid_o), 32'(v.valid));
    if (v.valid) check({p, " data"}, 32'(data_o), 32'(v.data));
    check({p, " inflight"}, 32'(inflight_o), 32'(v.infl));
    check({p, " err"}, 32'(err_o), 32'(v.err));
    check({p, " busy"}, 32'(busy_o), 32'(v.busy));
    check({p, " state"}, 32'(state_o), 32'(v.drain));
  endtask

  initial begin
    //        req done res       rdy fl | gnt st  valid   data     infl err busy    drain
    // single op, done 3 cycles after start
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0,    16'h0000, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0,    16'h0000, 1, 0, 1,    0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0,    16'h0000, 1, 0, 1,    0));
    tbl.push_back(mk(0, 1, 16'h3F80, 1, 0, 1, 0, BYP,  16'h3F80, 1, 0, 1,    0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, !BYP, 16'h3F80, 0, 0, !BYP, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 0,    16'h0000, 0, 0, 0,    0));
    // burst with back-pressure: four credits, then no grant
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 3, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 4, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h3F80, 0, 0, 0, 0, 0, 16'h0000, 4, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h4000, 0, 0, 0, 0, 1, 16'h3F80, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h402E, 0, 0, 0, 0, 1, 16'h3F80, 2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h4080, 0, 0, 0, 0, 1, 16'h3F80, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h3F80, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h3F80, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h4000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h402E, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h4080, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
    // same-cycle start, done and pop
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 0, 0, 1, 0, 0, 16'h0000, 2, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h2222, 1, 0, 1, 1, 1, 16'h1111, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h2222, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h3333, 1, 0, 1, 0, 1, 16'h2222, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h3333, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
    // flush with 2 in flight and 1 buffered, then drain
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h5555, 0, 0, 1, 0, 0, 16'h0000, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h5555, 2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 2, 0, 1, 1));
    tbl.push_back(mk(0, 1, 16'h6666, 1, 0, 0, 0, 0, 16'h0000, 2, 0, 1, 1));
    tbl.push_back(mk(0, 1, 16'h7777, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
    // spurious done: sticky error, nothing delivered
    tbl.push_back(mk(0, 1, 16'h8888, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0));

    do_reset("reset");
    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // randomized traffic, with a reset in the middle of it
    do_reset("reset2");
    for (int c = 0; c < 1600; c++) begin
      bit req, done, rdy, fl;
      req  = ($urandom_range(0, 99) < 60);
      done = (m_infl > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
      rdy  = ($urandom_range(0, 99) < 65);
      fl   = ($urandom_range(0, 99) < 3);
      step(req, done, DW'($urandom), rdy, fl);
      if (c == 800) do_reset("reset_mid");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
